// File: rtl/morse_pkg.sv
// Purpose : shared symbol codes, event codes and the button-edge priority encoder.
// Latency : n/a (constants and a combinational helper only).
// Backpressure: n/a.
package morse_pkg;

   // Two-bit symbol codes stored per slot in a letter.
   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;

   // One event is handled per tick.
   localparam logic [2:0] EV_NONE  = 3'd0;
   localparam logic [2:0] EV_DOT   = 3'd1;
   localparam logic [2:0] EV_DASH  = 3'd2;
   localparam logic [2:0] EV_SPACE = 3'd3;
   localparam logic [2:0] EV_END   = 3'd4;
   localparam logic [2:0] EV_CLEAR = 3'd5;

   // edges = {clear, endseq, space, dash, dot}; the highest-priority edge wins,
   // everything else seen on the same tick is discarded.
   function automatic logic [2:0] prio_event(input logic [4:0] edges);
      logic [2:0] ev;
      ev = EV_NONE;
      if (edges[4])      ev = EV_CLEAR;
      else if (edges[3]) ev = EV_END;
      else if (edges[2]) ev = EV_SPACE;
      else if (edges[1]) ev = EV_DASH;
      else if (edges[0]) ev = EV_DOT;
      return ev;
   endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// Purpose : first-word-fall-through FIFO of completed letters, with flush.
// Latency : a push is visible on head_dat the clk after the push edge.
// Backpressure: push while full is dropped (push_drop) unless a pop happens in the same clk.
// Ports   : clk/rst_n; push/push_dat write; pop advances head; flush empties;
//           head_dat (0 when empty), full, empty, push_drop.
module morse_letter_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty,
   output logic             push_drop
);

   localparam int AW = $clog2(DEPTH);

   // Extra MSB on each pointer distinguishes full from empty.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A flush wins over a pop in the same clk.
   assign pop_ok    = pop && !empty && !flush;
   // When full, a simultaneous pop frees the head slot, which the push reuses.
   assign push_ok   = push && !flush && (!full || pop_ok);
   assign push_drop = push && !flush && full && !pop_ok;
   assign head_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/morse_producer_fifo.sv
// Purpose : morse key front end; assembles dot/dash symbols into letters and queues them.
// Latency : an edge sampled on a tick is on letter_valid/letter_out the clk after that tick edge.
// Backpressure: consumer pops with rd_en; letters/symbols that do not fit set sticky overflow.
// Ports   : clk, Reset (async active-low); buttons Dot/Dash/Space/EndSeq/Clear; rd_en pop;
//           dot_buzzer/dash_buzzer tones; letter_out/letter_len/spa_end FIFO head;
//           letter_valid, full, overflow, sent (EndSeq accepted pulse).
module morse_producer_fifo
   import morse_pkg::*;
#(
   parameter int MAX_SYM   = 5,
   parameter int DEPTH     = 8,
   parameter int DIV       = 10,
   parameter int DOT_TICKS = 4
) (
   input  logic                           clk,
   input  logic                           Reset,
   input  logic                           Dot,
   input  logic                           Dash,
   input  logic                           Space,
   input  logic                           EndSeq,
   input  logic                           Clear,
   input  logic                           rd_en,
   output logic                           dot_buzzer,
   output logic                           dash_buzzer,
   output logic [2*MAX_SYM-1:0]           letter_out,
   output logic [$clog2(MAX_SYM+1)-1:0]   letter_len,
   output logic                           spa_end,
   output logic                           letter_valid,
   output logic                           full,
   output logic                           overflow,
   output logic                           sent
);

   localparam int LW = $clog2(MAX_SYM+1);
   localparam int BW = 2*MAX_SYM;
   localparam int EW = BW + LW + 1;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW = $clog2(3*DOT_TICKS+1);

   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV-1);
   localparam logic [LW-1:0] MAX_CNT   = LW'(MAX_SYM);
   localparam logic [TW-1:0] DOT_LOAD  = TW'(DOT_TICKS);
   localparam logic [TW-1:0] DASH_LOAD = TW'(3*DOT_TICKS);

   logic [CW-1:0] div_cnt;
   logic          tick;
   logic [4:0]    btn_raw, sync1, sync2, prev, edges;
   logic [2:0]    ev;
   logic [1:0]    sym_code;
   logic [BW-1:0] bits;
   logic [LW-1:0] sym_cnt;
   logic [TW-1:0] timer;
   logic          buz_dash;
   logic          push, flush, push_drop, empty;
   logic [EW-1:0] head_dat;

   assign tick    = (div_cnt == DIV_LAST);
   assign btn_raw = {Clear, EndSeq, Space, Dash, Dot};
   // prev only moves on ticks, so an edge is a rise between two consecutive ticks.
   assign edges   = tick ? (sync2 & ~prev) : 5'b0;
   assign ev      = prio_event(edges);

   assign sym_code = (ev == EV_DASH) ? SYM_DASH : ((ev == EV_DOT) ? SYM_DOT : SYM_NONE);
   // Space on an empty letter carries nothing; EndSeq always pushes a terminator.
   assign push     = ((ev == EV_SPACE) && (sym_cnt != '0)) || (ev == EV_END);
   assign flush    = (ev == EV_CLEAR);

   assign dot_buzzer  = (timer != '0) && !buz_dash;
   assign dash_buzzer = (timer != '0) &&  buz_dash;

   assign letter_valid = !empty;
   assign {spa_end, letter_len, letter_out} = head_dat;

   morse_letter_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (Reset),
      .push      (push),
      .push_dat  ({(ev == EV_END), sym_cnt, bits}),
      .pop       (rd_en),
      .flush     (flush),
      .head_dat  (head_dat),
      .full      (full),
      .empty     (empty),
      .push_drop (push_drop)
   );

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         div_cnt  <= '0;
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         bits     <= '0;
         sym_cnt  <= '0;
         timer    <= '0;
         buz_dash <= 1'b0;
         overflow <= 1'b0;
         sent     <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + CW'(1);
         sync1   <= btn_raw;
         sync2   <= sync1;
         if (tick) prev <= sync2;
         sent    <= (ev == EV_END) && !push_drop;

         if (tick && (timer != '0)) timer <= timer - TW'(1);

         case (ev)
            EV_DOT, EV_DASH: begin
               if (sym_cnt < MAX_CNT) begin
                  for (int i = 0; i < MAX_SYM; i++)
                     if (sym_cnt == LW'(i)) bits[2*i +: 2] <= sym_code;
                  sym_cnt  <= sym_cnt + LW'(1);
                  // A new symbol restarts the timer and hands the tone to its own buzzer.
                  timer    <= (ev == EV_DOT) ? DOT_LOAD : DASH_LOAD;
                  buz_dash <= (ev == EV_DASH);
               end else begin
                  overflow <= 1'b1;
               end
            end
            EV_SPACE, EV_END: begin
               bits    <= '0;
               sym_cnt <= '0;
            end
            EV_CLEAR: begin
               bits     <= '0;
               sym_cnt  <= '0;
               timer    <= '0;
               overflow <= 1'b0;
            end
            default: ;
         endcase

         if (push_drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_morse_producer_fifo.sv
// Purpose : directed, table-driven check of morse_producer_fifo (DIV=2, DOT_TICKS=2, MAX_SYM=5, DEPTH=4).
// Latency : each table step is a fixed-length press or pop window, then the outputs are compared.
// Backpressure: pops are explicit table steps driven through rd_en.
module tb_morse_producer_fifo;

   localparam int MAX_SYM = 5, DEPTH = 4, DIV = 2, DOT_TICKS = 2;

   localparam logic [4:0] B_DOT = 5'd1, B_DASH = 5'd2, B_SPC = 5'd4, B_END = 5'd8, B_CLR = 5'd16;

   logic       clk = 1'b0;
   logic       Reset;
   logic [4:0] btn;
   logic       rd_en;

   logic       dot_buzzer, dash_buzzer, spa_end, letter_valid, full, overflow, sent;
   logic [9:0] letter_out;
   logic [2:0] letter_len;

   always #5 clk = ~clk;

   morse_producer_fifo #(.MAX_SYM(MAX_SYM), .DEPTH(DEPTH), .DIV(DIV), .DOT_TICKS(DOT_TICKS)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .Dot          (btn[0]),
      .Dash         (btn[1]),
      .Space        (btn[2]),
      .EndSeq       (btn[3]),
      .Clear        (btn[4]),
      .rd_en        (rd_en),
      .dot_buzzer   (dot_buzzer),
      .dash_buzzer  (dash_buzzer),
      .letter_out   (letter_out),
      .letter_len   (letter_len),
      .spa_end      (spa_end),
      .letter_valid (letter_valid),
      .full         (full),
      .overflow     (overflow),
      .sent         (sent)
   );

   typedef struct {
      logic [4:0] btn;
      bit         pop;
      int         dot_c;
      int         dash_c;
      int         sent_c;
      bit         vld;
      logic [9:0] bits;
      int         len;
      bit         term;
      bit         full;
      bit         ovf;
   } vec_t;

   vec_t vt[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [4:0] b, input bit p, input int dc, input int dsc, input int sc,
                      input bit v, input logic [9:0] bt, input int ln, input bit tm,
                      input bit fl, input bit ov);
      vec_t e;
      e.btn = b; e.pop = p; e.dot_c = dc; e.dash_c = dsc; e.sent_c = sc;
      e.vld = v; e.bits = bt; e.len = ln; e.term = tm; e.full = fl; e.ovf = ov;
      vt.push_back(e);
   endtask

   // Press window: hold 10 clks, release 10 clks; counts buzzer and sent clks seen at negedges.
   // Pop window: rd_en for exactly one posedge, then settle.
   task automatic run_step(input vec_t v, output int dc, output int dsc, output int sc);
      dc = 0; dsc = 0; sc = 0;
      if (v.pop) begin
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
         repeat (3) begin
            if (dot_buzzer) dc++;
            if (dash_buzzer) dsc++;
            if (sent) sc++;
            @(negedge clk);
         end
      end else begin
         btn = v.btn;
         for (int k = 0; k < 20; k++) begin
            if (k == 10) btn = 5'd0;
            @(negedge clk);
            if (dot_buzzer) dc++;
            if (dash_buzzer) dsc++;
            if (sent) sc++;
         end
      end
   endtask

   task automatic check_step(input string tag, input vec_t v, input int dc, input int dsc, input int sc);
      chk({tag, ".dot_clks"},  dc,           v.dot_c);
      chk({tag, ".dash_clks"}, dsc,          v.dash_c);
      chk({tag, ".sent_clks"}, sc,           v.sent_c);
      chk({tag, ".valid"},     letter_valid, v.vld);
      chk({tag, ".bits"},      letter_out,   v.bits);
      chk({tag, ".len"},       letter_len,   v.len);
      chk({tag, ".term"},      spa_end,      v.term);
      chk({tag, ".full"},      full,         v.full);
      chk({tag, ".ovf"},       overflow,     v.ovf);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".valid"}, letter_valid, 0);
      chk({tag, ".bits"},  letter_out,   0);
      chk({tag, ".len"},   letter_len,   0);
      chk({tag, ".term"},  spa_end,      0);
      chk({tag, ".full"},  full,         0);
      chk({tag, ".ovf"},   overflow,     0);
      chk({tag, ".sent"},  sent,         0);
      chk({tag, ".dotb"},  dot_buzzer,   0);
      chk({tag, ".dashb"}, dash_buzzer,  0);
   endtask

   initial begin
      int   dc, dsc, sc;
      vec_t v;

      //   btn            pop dot dash sent  vld bits     len term full ovf
      add(B_DOT,          0,  4,  0,   0,    0,  10'h000, 0,  0,   0,   0);  // letter D-H-D
      add(B_DASH,         0,  0,  12,  0,    0,  10'h000, 0,  0,   0,   0);
      add(B_DOT,          0,  4,  0,   0,    0,  10'h000, 0,  0,   0,   0);
      add(B_SPC,          0,  0,  0,   0,    1,  10'h019, 3,  0,   0,   0);
      add(5'd0,           1,  0,  0,   0,    0,  10'h000, 0,  0,   0,   0);
      add(B_DASH,         0,  0,  12,  0,    0,  10'h000, 0,  0,   0,   0);  // dash + EndSeq
      add(B_END,          0,  0,  0,   1,    1,  10'h002, 1,  1,   0,   0);
      add(5'd0,           1,  0,  0,   0,    0,  10'h000, 0,  0,   0,   0);
      add(B_END,          0,  0,  0,   1,    1,  10'h000, 0,  1,   0,   0);  // bare EndSeq
      add(5'd0,           1,  0,  0,   0,    0,  10'h000, 0,  0,   0,   0);
      for (int i = 0; i < 5; i++)
         add(B_DOT,       0,  4,  0,   0,    0,  10'h000, 0,  0,   0,   0);  // fill letter
      add(B_DOT,          0,  0,  0,   0,    0,  10'h000, 0,  0,   0,   1);  // sixth dot dropped
      add(B_SPC,          0,  0,  0,   0,    1,  10'h155, 5,  0,   0,   1);
      add(5'd0,           1,  0,  0,   0,    0,  10'h000, 0,  0,   0,   1);
      add(B_CLR,          0,  0,  0,   0,    0,  10'h000, 0,  0,   0,   0);
      add(B_DOT,          0,  4,  0,   0,    0,  10'h000, 0,  0,   0,   0);  // A = D,Space
      add(B_SPC,          0,  0,  0,   0,    1,  10'h001, 1,  0,   0,   0);
      add(B_DASH,         0,  0,  12,  0,    1,  10'h001, 1,  0,   0,   0);  // B = H,End
      add(B_END,          0,  0,  0,   1,    1,  10'h001, 1,  0,   0,   0);
      add(B_END,          0,  0,  0,   1,    1,  10'h001, 1,  0,   0,   0);  // C = End
      add(B_DOT,          0,  4,  0,   0,    1,  10'h001, 1,  0,   0,   0);  // D = D,D,Space
      add(B_DOT,          0,  4,  0,   0,    1,  10'h001, 1,  0,   0,   0);
      add(B_SPC,          0,  0,  0,   0,    1,  10'h001, 1,  0,   1,   0);
      add(B_DASH,         0,  0,  12,  0,    1,  10'h001, 1,  0,   1,   0);  // E = H,End dropped
      add(B_END,          0,  0,  0,   0,    1,  10'h001, 1,  0,   1,   1);
      add(5'd0,           1,  0,  0,   0,    1,  10'h002, 1,  1,   0,   1);
      add(5'd0,           1,  0,  0,   0,    1,  10'h000, 0,  1,   0,   1);
      add(5'd0,           1,  0,  0,   0,    1,  10'h005, 2,  0,   0,   1);
      add(5'd0,           1,  0,  0,   0,    0,  10'h000, 0,  0,   0,   1);
      add(B_DOT | B_SPC,  0,  0,  0,   0,    0,  10'h000, 0,  0,   0,   1);  // Space outranks Dot
      add(B_END,          0,  0,  0,   1,    1,  10'h000, 0,  1,   0,   1);
      add(B_END,          0,  0,  0,   1,    1,  10'h000, 0,  1,   0,   1);
      add(B_CLR,          0,  0,  0,   0,    0,  10'h000, 0,  0,   0,   0);  // flush 2 entries

      Reset = 1'b0;
      btn   = 5'd0;
      rd_en = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      Reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vt.size(); i++) begin
         run_step(vt[i], dc, dsc, sc);
         check_step($sformatf("step%0d", i), vt[i], dc, dsc, sc);
      end

      // Reset in the middle of operation: two letters queued and a dash tone running.
      v = '{btn: B_END, pop: 0, dot_c: 0, dash_c: 0, sent_c: 1, vld: 1, bits: 10'h000,
            len: 0, term: 1, full: 0, ovf: 0};
      run_step(v, dc, dsc, sc);
      run_step(v, dc, dsc, sc);
      check_step("rst_pre", v, dc, dsc, sc);
      btn = B_DASH;
      repeat (6) @(negedge clk);
      chk("rst_pre.dash_on", dash_buzzer, 1);
      #2 Reset = 1'b0;
      #1 check_all_zero("rst_mid");
      btn = 5'd0;
      @(negedge clk);
      Reset = 1'b1;
      repeat (2) @(negedge clk);
      v = '{btn: B_DOT, pop: 0, dot_c: 4, dash_c: 0, sent_c: 0, vld: 0, bits: 10'h000,
            len: 0, term: 0, full: 0, ovf: 0};
      run_step(v, dc, dsc, sc);
      check_step("rst_dot", v, dc, dsc, sc);
      v = '{btn: B_SPC, pop: 0, dot_c: 0, dash_c: 0, sent_c: 0, vld: 1, bits: 10'h001,
            len: 1, term: 0, full: 0, ovf: 0};
      run_step(v, dc, dsc, sc);
      check_step("rst_spc", v, dc, dsc, sc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
